uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 65535: max idle clocks between bytes of one command, and max clocks awaiting i_Bus_Ack.
REQ-002 Parameter ACK_BYTE, default 8'h06: response byte for a completed write.
REQ-003 Parameter NAK_BYTE, default 8'h15: response byte for an unknown opcode or a bus timeout.
REQ-004 The block SHALL use one clock: i_Clock, input, 1 bit, rising-edge system clock.
REQ-005 Reset SHALL be synchronous and active-low: i_Rst_n, input, 1 bit.
REQ-006 i_RX_DV  input  1: one-cycle strobe, received byte valid.
REQ-007 i_RX_Byte  input  8: received byte, valid while i_RX_DV=1.
REQ-008 o_TX_DV  output  1: one-cycle strobe to the transmitter.
REQ-009 o_TX_Byte  output  8: byte to transmit, stable from the o_TX_DV cycle until the response completes.
REQ-010 i_TX_Active  input  1: transmitter busy.
REQ-011 o_Bus_Addr  output  16: bus address.
REQ-012 o_Bus_WData  output  8: bus write data.
REQ-013 o_Bus_Wr / o_Bus_Rd  output  1 each: request levels, held until ack or timeout.
REQ-014 i_Bus_RData  input  8: read data, valid in the i_Bus_Ack cycle.
REQ-015 i_Bus_Ack  input  1: one-cycle bus completion.
REQ-016 o_Busy  output  1: high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, GET_AH, GET_AL, GET_DATA, BUS, TX_START, TX_WAIT_ACT, TX_WAIT_DONE.
REQ-018 In IDLE, an i_RX_DV pulse SHALL latch the opcode.
  - 8'h57 ('W') or 8'h52 ('R') -> GET_AH.
  - Any other opcode -> load o_TX_Byte=NAK_BYTE and go to TX_START.
REQ-019 GET_AH SHALL latch the byte into o_Bus_Addr[15:8] and go to GET_AL; GET_AL SHALL latch the byte into o_Bus_Addr[7:0].
  - For 'W' -> GET_DATA.
  - For 'R' -> BUS with o_Bus_Rd=1 from the next cycle.
REQ-020 GET_DATA SHALL latch the byte into o_Bus_WData and go to BUS with o_Bus_Wr=1 from the next cycle.
REQ-021 In BUS, on i_Bus_Ack the block SHALL deassert Wr/Rd in the next cycle, load o_TX_Byte (ACK_BYTE for write, i_Bus_RData for read), and go to TX_START.
REQ-022 o_Bus_Wr and o_Bus_Rd SHALL never be high simultaneously; each request SHALL last at least one cycle.
REQ-023 In TX_START, when i_TX_Active=0, the block SHALL drive o_TX_DV=1 for exactly one cycle and go to TX_WAIT_ACT; while i_TX_Active=1 it SHALL wait.
REQ-024 TX_WAIT_ACT SHALL go to TX_WAIT_DONE on i_TX_Active=1; TX_WAIT_DONE SHALL go to IDLE on i_TX_Active=0.
REQ-025 A 17-bit timeout counter SHALL clear on every state change and every accepted i_RX_DV, and increment in GET_AH, GET_AL, GET_DATA and BUS.
REQ-026 When the counter reaches TIMEOUT_CLKS:
  - In GET_AH, GET_AL or GET_DATA -> IDLE, no response, bus untouched.
  - In BUS -> drop Wr/Rd next cycle, load NAK_BYTE, go to TX_START.
REQ-027 i_RX_DV pulses in BUS, TX_START, TX_WAIT_ACT or TX_WAIT_DONE SHALL be discarded and SHALL NOT alter any latched field.
REQ-028 An i_RX_DV coinciding with the timeout cycle: the timeout SHALL take priority and the byte SHALL be discarded.
REQ-029 An i_Bus_Ack coinciding with the timeout cycle: the ack SHALL take priority (normal response).
REQ-030 An i_Bus_Ack received outside BUS SHALL be ignored.
REQ-031 Minimum latency: from the last command byte's i_RX_DV to o_Bus_Wr/o_Bus_Rd = 1 cycle; from i_Bus_Ack to o_TX_DV = 2 cycles when i_TX_Active=0.

Reset
REQ-032 With i_Rst_n=0 at a rising edge, the next state SHALL be IDLE with all outputs 0: o_TX_DV, o_TX_Byte, o_Bus_Addr, o_Bus_WData, o_Bus_Wr, o_Bus_Rd, o_Busy; timeout counter 0.
REQ-033 Reset asserted mid-command, mid-bus-cycle or mid-response SHALL abort immediately with no further o_TX_DV or bus request.
REQ-034 The first i_RX_DV accepted SHALL be in the cycle after i_Rst_n returns high.

Verification
REQ-035 Write: RX 57,12,34,A5 -> one Wr cycle-burst with Addr=1234, WData=A5; after Ack, one o_TX_DV with o_TX_Byte=06.
REQ-036 Read: RX 52,80,01; bus returns 3C on Ack after 5 cycles -> Rd held 5 cycles, Addr=8001, TX byte 3C, exactly one o_TX_DV.
REQ-037 Bad opcode: RX 41 -> TX 15, no bus activity; hold i_TX_Active=1 beforehand and check that o_TX_DV waits until it drops.
REQ-038 Timeouts (TIMEOUT_CLKS=16):
  - RX 57,12 then silence -> IDLE after 16 cycles, no TX.
  - Read with no Ack -> Rd drops, TX 15.
REQ-039 Discard/reset: RX bytes during TX_WAIT_DONE are ignored, and the next command still decodes; reset asserted in BUS -> Rd=0 next cycle, o_Busy=0, no TX.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes W/R commands from a byte stream, runs one bus access
// and returns a single response byte (ACK, read data or NAK).
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CLKS = 65535,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Active,
  output logic [15:0] o_Bus_Addr,
  output logic [7:0]  o_Bus_WData,
  output logic        o_Bus_Wr,
  output logic        o_Bus_Rd,
  input  logic [7:0]  i_Bus_RData,
  input  logic        i_Bus_Ack,
  output logic        o_Busy
);

  localparam logic [7:0]  OpWrite    = 8'h57;
  localparam logic [7:0]  OpRead     = 8'h52;
  localparam logic [16:0] TimeoutCnt = 17'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {
    StIdle,
    StGetAh,
    StGetAl,
    StGetData,
    StBus,
    StTxStart,
    StTxWaitAct,
    StTxWaitDone
  } state_e;

  state_e      state_q;
  logic [16:0] timeout_cnt_q;
  logic        cmd_write_q;
  logic        timeout;

  assign timeout = (timeout_cnt_q == TimeoutCnt);
  assign o_Busy  = (state_q != StIdle);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q       <= StIdle;
      timeout_cnt_q <= '0;
      cmd_write_q   <= 1'b0;
      o_TX_DV       <= 1'b0;
      o_TX_Byte     <= '0;
      o_Bus_Addr    <= '0;
      o_Bus_WData   <= '0;
      o_Bus_Wr      <= 1'b0;
      o_Bus_Rd      <= 1'b0;
    end else begin
      o_TX_DV <= 1'b0;
      unique case (state_q)
        StIdle: begin
          timeout_cnt_q <= '0;
          if (i_RX_DV) begin
            if (i_RX_Byte == OpWrite || i_RX_Byte == OpRead) begin
              cmd_write_q <= (i_RX_Byte == OpWrite);
              state_q     <= StGetAh;
            end else begin
              o_TX_Byte <= NAK_BYTE;
              state_q   <= StTxStart;
            end
          end
        end

        // Timeout is checked first so a byte landing on the timeout cycle is dropped.
        StGetAh: begin
          if (timeout) begin
            timeout_cnt_q <= '0;
            state_q       <= StIdle;
          end else if (i_RX_DV) begin
            timeout_cnt_q    <= '0;
            o_Bus_Addr[15:8] <= i_RX_Byte;
            state_q          <= StGetAl;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 17'd1;
          end
        end

        StGetAl: begin
          if (timeout) begin
            timeout_cnt_q <= '0;
            state_q       <= StIdle;
          end else if (i_RX_DV) begin
            timeout_cnt_q   <= '0;
            o_Bus_Addr[7:0] <= i_RX_Byte;
            if (cmd_write_q) begin
              state_q <= StGetData;
            end else begin
              o_Bus_Rd <= 1'b1;
              state_q  <= StBus;
            end
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 17'd1;
          end
        end

        StGetData: begin
          if (timeout) begin
            timeout_cnt_q <= '0;
            state_q       <= StIdle;
          end else if (i_RX_DV) begin
            timeout_cnt_q <= '0;
            o_Bus_WData   <= i_RX_Byte;
            o_Bus_Wr      <= 1'b1;
            state_q       <= StBus;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 17'd1;
          end
        end

        // Ack wins over a simultaneous timeout.
        StBus: begin
          if (i_Bus_Ack) begin
            timeout_cnt_q <= '0;
            o_Bus_Wr      <= 1'b0;
            o_Bus_Rd      <= 1'b0;
            o_TX_Byte     <= cmd_write_q ? ACK_BYTE : i_Bus_RData;
            state_q       <= StTxStart;
          end else if (timeout) begin
            timeout_cnt_q <= '0;
            o_Bus_Wr      <= 1'b0;
            o_Bus_Rd      <= 1'b0;
            o_TX_Byte     <= NAK_BYTE;
            state_q       <= StTxStart;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 17'd1;
          end
        end

        StTxStart: begin
          timeout_cnt_q <= '0;
          if (!i_TX_Active) begin
            o_TX_DV <= 1'b1;
            state_q <= StTxWaitAct;
          end
        end

        StTxWaitAct: begin
          timeout_cnt_q <= '0;
          if (i_TX_Active) state_q <= StTxWaitDone;
        end

        StTxWaitDone: begin
          timeout_cnt_q <= '0;
          if (!i_TX_Active) state_q <= StIdle;
        end

        default: begin
          timeout_cnt_q <= '0;
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a small transmitter and bus responder model.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        tx_active;
  logic [15:0] o_Bus_Addr;
  logic [7:0]  o_Bus_WData;
  logic        o_Bus_Wr;
  logic        o_Bus_Rd;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_ack;
  logic        o_Busy;

  // Transmitter model: goes active for tx_len cycles after each o_TX_DV.
  logic tx_auto = 1'b1;
  logic tx_force = 1'b0;
  logic tx_model_active = 1'b0;
  int   tx_len = 4;
  int   tx_busy_cnt = 0;
  assign tx_active = tx_auto ? tx_model_active : tx_force;

  // Bus model: acks when the request has been high for ack_after cycles.
  logic bus_en = 1'b1;
  logic ack_poke = 1'b0;
  logic bus_ack_model = 1'b0;
  int   ack_after = 1;
  int   req_age = 0;
  assign bus_ack = bus_ack_model | ack_poke;

  int n_vec = 0;
  int n_err = 0;
  int tx_count = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int both_high = 0;
  logic [7:0]  tx_seen = 8'h00;
  logic [15:0] addr_seen = 16'h0000;
  logic [7:0]  wdata_seen = 8'h00;

  uart_cmd_ctrl #(
    .TIMEOUT_CLKS (16),
    .ACK_BYTE     (8'h06),
    .NAK_BYTE     (8'h15)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (tx_active),
    .o_Bus_Addr  (o_Bus_Addr),
    .o_Bus_WData (o_Bus_WData),
    .o_Bus_Wr    (o_Bus_Wr),
    .o_Bus_Rd    (o_Bus_Rd),
    .i_Bus_RData (bus_rdata),
    .i_Bus_Ack   (bus_ack),
    .o_Busy      (o_Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (o_TX_DV) tx_busy_cnt = tx_len;
    else if (tx_busy_cnt != 0) tx_busy_cnt = tx_busy_cnt - 1;
    tx_model_active = (tx_busy_cnt != 0);
    if (o_Bus_Wr || o_Bus_Rd) req_age = req_age + 1;
    else req_age = 0;
    bus_ack_model = bus_en && (req_age == ack_after);
  end

  always @(negedge clk) begin
    if (o_TX_DV) begin
      tx_count = tx_count + 1;
      tx_seen  = o_TX_Byte;
    end
    if (o_Bus_Wr) wr_cycles = wr_cycles + 1;
    if (o_Bus_Rd) rd_cycles = rd_cycles + 1;
    if (o_Bus_Wr && o_Bus_Rd) both_high = both_high + 1;
    if (o_Bus_Wr || o_Bus_Rd) begin
      addr_seen  = o_Bus_Addr;
      wdata_seen = o_Bus_WData;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (o_Busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (o_Busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: o_Busy=%b after %0d cycles, required 0", name, o_Busy, bound);
    end
  endtask

  task automatic test_reset;
    cycles(3);
    n_vec++;
    if ({o_TX_DV, o_TX_Byte, o_Bus_Addr, o_Bus_WData, o_Bus_Wr, o_Bus_Rd, o_Busy} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got %b/%h/%h/%h/%b/%b/%b, required all 0", o_TX_DV,
               o_TX_Byte, o_Bus_Addr, o_Bus_WData, o_Bus_Wr, o_Bus_Rd, o_Busy);
    end
    // First byte is offered in the very cycle after reset releases.
    rst_n = 1'b1;
    send_byte(8'h41);
    n_vec++;
    if (o_Busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset first byte: o_Busy=%b, required 1", o_Busy);
    end
    wait_idle("reset", 40);
    n_vec++;
    if (tx_count !== 1 || tx_seen !== 8'h15) begin
      n_err++;
      $display("FAIL reset first byte resp: count=%0d byte=%h, required 1/15", tx_count, tx_seen);
    end
    cycles(2);
  endtask

  task automatic test_write;
    int tx0 = tx_count, wr0 = wr_cycles, rd0 = rd_cycles;
    ack_after = 1;
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    n_vec++;
    if (o_Bus_Wr !== 1'b1 || o_Bus_Rd !== 1'b0) begin
      n_err++;
      $display("FAIL write latency: Wr=%b Rd=%b, required 1/0", o_Bus_Wr, o_Bus_Rd);
    end
    cycles(2);
    n_vec++;
    if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h06) begin
      n_err++;
      $display("FAIL write ack->tx: TX_DV=%b byte=%h, required 1/06", o_TX_DV, o_TX_Byte);
    end
    wait_idle("write", 40);
    n_vec++;
    if (wr_cycles - wr0 !== 1 || rd_cycles - rd0 !== 0 || addr_seen !== 16'h1234 ||
        wdata_seen !== 8'hA5) begin
      n_err++;
      $display("FAIL write bus: wr=%0d rd=%0d addr=%h data=%h, required 1/0/1234/A5",
               wr_cycles - wr0, rd_cycles - rd0, addr_seen, wdata_seen);
    end
    n_vec++;
    if (tx_count - tx0 !== 1 || tx_seen !== 8'h06) begin
      n_err++;
      $display("FAIL write resp: count=%0d byte=%h, required 1/06", tx_count - tx0, tx_seen);
    end
    cycles(2);
  endtask

  task automatic test_read;
    int tx0 = tx_count, wr0 = wr_cycles, rd0 = rd_cycles;
    ack_after = 5;
    bus_rdata = 8'h3C;
    send_byte(8'h52); send_byte(8'h80); send_byte(8'h01);
    n_vec++;
    if (o_Bus_Rd !== 1'b1 || o_Bus_Wr !== 1'b0) begin
      n_err++;
      $display("FAIL read latency: Rd=%b Wr=%b, required 1/0", o_Bus_Rd, o_Bus_Wr);
    end
    wait_idle("read", 60);
    n_vec++;
    if (rd_cycles - rd0 !== 5 || wr_cycles - wr0 !== 0 || addr_seen !== 16'h8001) begin
      n_err++;
      $display("FAIL read bus: rd=%0d wr=%0d addr=%h, required 5/0/8001",
               rd_cycles - rd0, wr_cycles - wr0, addr_seen);
    end
    n_vec++;
    if (tx_count - tx0 !== 1 || tx_seen !== 8'h3C) begin
      n_err++;
      $display("FAIL read resp: count=%0d byte=%h, required 1/3C", tx_count - tx0, tx_seen);
    end
    cycles(2);
  endtask

  task automatic test_bad_opcode;
    int tx0 = tx_count, wr0 = wr_cycles, rd0 = rd_cycles;
    tx_force = 1'b1;
    tx_auto  = 1'b0;
    send_byte(8'h41);
    cycles(5);
    n_vec++;
    if (o_Busy !== 1'b1 || tx_count !== tx0 || o_TX_Byte !== 8'h15) begin
      n_err++;
      $display("FAIL nak held: busy=%b txcount=%0d byte=%h, required 1/%0d/15",
               o_Busy, tx_count, o_TX_Byte, tx0);
    end
    tx_force = 1'b0;
    cycles(1);
    n_vec++;
    if (o_TX_DV !== 1'b1) begin
      n_err++;
      $display("FAIL nak release: TX_DV=%b, required 1", o_TX_DV);
    end
    tx_force = 1'b1;
    cycles(1);
    n_vec++;
    if (o_TX_DV !== 1'b0) begin
      n_err++;
      $display("FAIL nak one-shot: TX_DV=%b, required 0", o_TX_DV);
    end
    cycles(2);
    tx_force = 1'b0;
    wait_idle("nak", 10);
    n_vec++;
    if (tx_count - tx0 !== 1 || tx_seen !== 8'h15 || wr_cycles !== wr0 || rd_cycles !== rd0) begin
      n_err++;
      $display("FAIL nak resp: count=%0d byte=%h wr=%0d rd=%0d, required 1/15/0/0",
               tx_count - tx0, tx_seen, wr_cycles - wr0, rd_cycles - rd0);
    end
    tx_auto = 1'b1;
    cycles(10);
  endtask

  task automatic test_timeouts;
    int tx0 = tx_count, rd0;
    send_byte(8'h57); send_byte(8'h12);
    cycles(16);
    n_vec++;
    if (o_Busy !== 1'b1) begin
      n_err++;
      $display("FAIL get timeout early: busy=%b at 16 cycles, required 1", o_Busy);
    end
    cycles(1);
    n_vec++;
    if (o_Busy !== 1'b0 || tx_count !== tx0 || o_Bus_Wr !== 1'b0) begin
      n_err++;
      $display("FAIL get timeout: busy=%b txcount=%0d wr=%b, required 0/%0d/0",
               o_Busy, tx_count, o_Bus_Wr, tx0);
    end
    // Read with no ack: Rd held 17 cycles (counter 0..16), then NAK.
    bus_en = 1'b0;
    rd0 = rd_cycles;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    wait_idle("bus timeout", 60);
    n_vec++;
    if (rd_cycles - rd0 !== 17 || tx_count - tx0 !== 1 || tx_seen !== 8'h15) begin
      n_err++;
      $display("FAIL bus timeout: rd=%0d count=%0d byte=%h, required 17/1/15",
               rd_cycles - rd0, tx_count - tx0, tx_seen);
    end
    // Ack on the timeout cycle takes priority.
    bus_en = 1'b1;
    ack_after = 17;
    bus_rdata = 8'hC3;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    wait_idle("ack vs timeout", 60);
    n_vec++;
    if (tx_count - tx0 !== 2 || tx_seen !== 8'hC3) begin
      n_err++;
      $display("FAIL ack vs timeout: count=%0d byte=%h, required 2/C3", tx_count - tx0, tx_seen);
    end
    cycles(2);
  endtask

  task automatic test_discard;
    int tx0 = tx_count;
    int n = 0;
    tx_len = 8;
    ack_after = 1;
    send_byte(8'h57); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h11);
    while (!o_TX_DV && n < 20) begin cycles(1); n++; end
    cycles(1);
    send_byte(8'h52); send_byte(8'h41); send_byte(8'h99);
    wait_idle("discard", 30);
    n_vec++;
    if (o_Bus_Addr !== 16'hABCD || o_Bus_WData !== 8'h11 || tx_count - tx0 !== 1) begin
      n_err++;
      $display("FAIL discard fields: addr=%h data=%h count=%0d, required ABCD/11/1",
               o_Bus_Addr, o_Bus_WData, tx_count - tx0);
    end
    tx_len = 4;
    ack_after = 2;
    bus_rdata = 8'h5A;
    send_byte(8'h52); send_byte(8'h80); send_byte(8'h01);
    n_vec++;
    if (o_Bus_Rd !== 1'b1 || o_Bus_Addr !== 16'h8001) begin
      n_err++;
      $display("FAIL discard next cmd: Rd=%b addr=%h, required 1/8001", o_Bus_Rd, o_Bus_Addr);
    end
    wait_idle("discard next", 40);
    n_vec++;
    if (tx_count - tx0 !== 2 || tx_seen !== 8'h5A) begin
      n_err++;
      $display("FAIL discard next resp: count=%0d byte=%h, required 2/5A",
               tx_count - tx0, tx_seen);
    end
    cycles(2);
  endtask

  task automatic test_ack_ignored;
    int tx0 = tx_count;
    ack_poke = 1'b1;
    cycles(1);
    ack_poke = 1'b0;
    cycles(3);
    n_vec++;
    if (o_Busy !== 1'b0 || tx_count !== tx0) begin
      n_err++;
      $display("FAIL stray ack: busy=%b count=%0d, required 0/%0d", o_Busy, tx_count, tx0);
    end
  endtask

  task automatic test_reset_in_bus;
    int tx0 = tx_count;
    bus_en = 1'b0;
    send_byte(8'h52); send_byte(8'h55); send_byte(8'h66);
    cycles(3);
    rst_n = 1'b0;
    cycles(1);
    n_vec++;
    if (o_Bus_Rd !== 1'b0 || o_Busy !== 1'b0 || o_Bus_Addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset in bus: Rd=%b busy=%b addr=%h, required 0/0/0000",
               o_Bus_Rd, o_Busy, o_Bus_Addr);
    end
    rst_n = 1'b1;
    bus_en = 1'b1;
    cycles(40);
    n_vec++;
    if (tx_count !== tx0 || o_Bus_Rd !== 1'b0 || o_Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset abort: count=%0d Rd=%b busy=%b, required %0d/0/0",
               tx_count, o_Bus_Rd, o_Busy, tx0);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_write;
    test_read;
    test_bad_opcode;
    test_timeouts;
    test_discard;
    test_ack_ignored;
    test_reset_in_bus;
    n_vec++;
    if (both_high !== 0) begin
      n_err++;
      $display("FAIL wr/rd exclusive: %0d cycles with both high, required 0", both_high);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
